// File: rtl/i2c_lcd_backpack_responder.sv
// Write-only I2C target modelling a PCF8574 LCD backpack; rebuilds HD44780 nibbles into bytes.
// byte_valid 3 clk after raw SCL rise of bit 0, lcd_valid 1 clk later; no backpressure (ACKs every byte).
module i2c_lcd_backpack_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h27
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       scl,
    input  logic       sda_in,
    input  logic       nibble_sync,
    output logic       sda_pull_low,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       backlight,
    output logic [7:0] lcd_byte,
    output logic       lcd_rs,
    output logic       lcd_valid,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_prev;
    logic       sda_s1, sda_s2, sda_prev;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       en_prev;
    logic       nib_low;

    logic       scl_rise, scl_fall, start_det, stop_det, en_fall;
    logic [7:0] shift_next;

    assign scl_rise   = scl_s2 & ~scl_prev;
    assign scl_fall   = ~scl_s2 & scl_prev;
    assign start_det  = scl_s2 & scl_prev & sda_prev & ~sda_s2;
    assign stop_det   = scl_s2 & scl_prev & ~sda_prev & sda_s2;
    // The 8th bit is folded in combinationally so byte_out lands on the same edge as the rise.
    assign shift_next = {shift[6:0], sda_s2};

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state        <= IDLE;
            scl_s1       <= 1'b1;
            scl_s2       <= 1'b1;
            scl_prev     <= 1'b1;
            sda_s1       <= 1'b1;
            sda_s2       <= 1'b1;
            sda_prev     <= 1'b1;
            shift        <= 8'h00;
            bit_cnt      <= 3'd0;
            sda_pull_low <= 1'b0;
            byte_out     <= 8'h00;
            byte_valid   <= 1'b0;
            backlight    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            scl_s1     <= scl;
            scl_s2     <= scl_s1;
            scl_prev   <= scl_s2;
            sda_s1     <= sda_in;
            sda_s2     <= sda_s1;
            sda_prev   <= sda_s2;
            byte_valid <= 1'b0;

            if (start_det) begin
                state        <= ADDR;
                bit_cnt      <= 3'd0;
                busy         <= 1'b1;
                sda_pull_low <= 1'b0;
            end else if (stop_det) begin
                state        <= IDLE;
                busy         <= 1'b0;
                sda_pull_low <= 1'b0;
            end else begin
                case (state)
                    ADDR, DATA: begin
                        if (scl_rise) begin
                            shift   <= shift_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ADDR) begin
                                    state <= (shift_next[7:1] == DEV_ADDR && !shift_next[0])
                                             ? ADDR_ACK : IGNORE;
                                end else begin
                                    byte_out   <= shift_next;
                                    byte_valid <= 1'b1;
                                    backlight  <= shift_next[3];
                                    state      <= DATA_ACK;
                                end
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        // First SCL fall after bit 0 starts the ACK slot, the second ends it.
                        if (scl_fall) begin
                            if (!sda_pull_low) begin
                                sda_pull_low <= 1'b1;
                            end else begin
                                sda_pull_low <= 1'b0;
                                bit_cnt      <= 3'd0;
                                state        <= DATA;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte layout: P0=RS, P1=RW, P2=EN, P3=BL, P7:4=D7:4.
    assign en_fall = byte_valid & en_prev & ~byte_out[2] & ~byte_out[1];

    always_ff @(posedge clk) begin
        if (reset_p) begin
            en_prev   <= 1'b0;
            nib_low   <= 1'b0;
            lcd_byte  <= 8'h00;
            lcd_rs    <= 1'b0;
            lcd_valid <= 1'b0;
        end else begin
            lcd_valid <= 1'b0;
            if (byte_valid) begin
                en_prev <= byte_out[2];
            end
            if (en_fall) begin
                if (nibble_sync || !nib_low) begin
                    lcd_byte[7:4] <= byte_out[7:4];
                    lcd_rs        <= byte_out[0];
                    nib_low       <= 1'b1;
                end else begin
                    lcd_byte[3:0] <= byte_out[7:4];
                    lcd_valid     <= 1'b1;
                    nib_low       <= 1'b0;
                end
            end else if (nibble_sync) begin
                nib_low <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_lcd_backpack_responder.sv
// Directed bench: bit-banged I2C master with open-drain bus model against the backpack responder.
module tb_i2c_lcd_backpack_responder;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       nibble_sync = 1'b0;
    logic       sda_bus;
    logic       sda_pull_low;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       backlight;
    logic [7:0] lcd_byte;
    logic       lcd_rs;
    logic       lcd_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bv_cnt = 0;
    int bv_cyc = 0;
    int lv_cnt = 0;
    int pull_cnt = 0;
    int last_rise = 0;

    assign sda_bus = sda_m & ~sda_pull_low;

    always #5 clk = ~clk;

    i2c_lcd_backpack_responder #(.DEV_ADDR(7'h27)) dut (
        .clk          (clk),
        .reset_p      (reset_p),
        .scl          (scl_m),
        .sda_in       (sda_bus),
        .nibble_sync  (nibble_sync),
        .sda_pull_low (sda_pull_low),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .backlight    (backlight),
        .lcd_byte     (lcd_byte),
        .lcd_rs       (lcd_rs),
        .lcd_valid    (lcd_valid),
        .busy         (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid) begin
            bv_cnt = bv_cnt + 1;
            bv_cyc = cyc;
        end
        if (lcd_valid) lv_cnt = lv_cnt + 1;
        if (sda_pull_low) pull_cnt = pull_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (4) @(negedge clk);
    endtask

    task automatic start_cond();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; q();
        scl_m = 1'b1;
        last_rise = cyc;
        q(); q();
        scl_m = 1'b0; q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        ack = (sda_bus == 1'b0);
        q();
        scl_m = 1'b0; q();
    endtask

    task automatic send_list(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        logic a;
        send_byte(b0, a);
        send_byte(b1, a);
        send_byte(b2, a);
        send_byte(b3, a);
    endtask

    initial begin
        logic       ack;
        int         bv0, lv0, p0;
        logic [7:0] pat;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pull", sda_pull_low, 0);
        chk("rst_outs", {byte_out, byte_valid, backlight, lcd_byte, lcd_rs, lcd_valid}, 0);
        chk("rst_busy", busy, 0);
        reset_p = 1'b0;
        repeat (4) @(negedge clk);

        // Basic write 0x27 / 0x5C
        bv0 = bv_cnt;
        start_cond();
        chk("busy_after_start", busy, 1);
        send_byte(8'h4E, ack);
        chk("addr_ack", ack, 1);
        send_byte(8'h5C, ack);
        chk("data_ack", ack, 1);
        chk("byte_out_5c", byte_out, 8'h5C);
        chk("bv_count_1", bv_cnt - bv0, 1);
        chk("bv_latency", bv_cyc - last_rise, 3);
        chk("backlight_1", backlight, 1);
        stop_cond();
        chk("busy_after_stop", busy, 0);

        // Wrong address 0x3F is ignored, repeated START to 0x27 accepted
        bv0 = bv_cnt; p0 = pull_cnt;
        start_cond();
        send_byte(8'h7E, ack);
        chk("wrong_addr_nack", ack, 0);
        send_byte(8'h55, ack);
        chk("ignore_no_pull", pull_cnt - p0, 0);
        chk("ignore_no_bv", bv_cnt - bv0, 0);
        start_cond();
        send_byte(8'h4E, ack);
        chk("addr_after_ignore", ack, 1);
        stop_cond();

        // Read request NACKed
        start_cond();
        send_byte(8'h4F, ack);
        chk("read_nack", ack, 0);
        chk("read_busy", busy, 1);
        stop_cond();
        chk("read_stop_idle", busy, 0);

        // Nibble assembly; RW=1 pair in the middle must not count
        lv0 = lv_cnt;
        start_cond();
        send_byte(8'h4E, ack);
        send_list(8'h4D, 8'h49, 8'h3E, 8'h3A);
        send_byte(8'h1D, ack);
        send_byte(8'h19, ack);
        repeat (2) @(negedge clk);
        chk("lcd_count", lv_cnt - lv0, 1);
        chk("lcd_byte_41", lcd_byte, 8'h41);
        chk("lcd_rs_1", lcd_rs, 1);

        // nibble_sync realigns phase mid-character
        lv0 = lv_cnt;
        send_byte(8'h4D, ack);
        send_byte(8'h49, ack);
        @(negedge clk) nibble_sync = 1'b1;
        @(negedge clk) nibble_sync = 1'b0;
        send_list(8'h6D, 8'h69, 8'h2C, 8'h28);
        repeat (2) @(negedge clk);
        chk("sync_count", lv_cnt - lv0, 1);
        chk("sync_byte_62", lcd_byte, 8'h62);
        chk("sync_rs_hi", lcd_rs, 1);

        // Repeated START aborts a half byte
        bv0 = bv_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        start_cond();
        send_byte(8'h4E, ack);
        chk("rs_addr_ack", ack, 1);
        send_byte(8'h08, ack);
        chk("rs_byte_out", byte_out, 8'h08);
        chk("rs_bv_count", bv_cnt - bv0, 1);
        stop_cond();

        // Reset during an ACK, with nibble phase left LOW
        start_cond();
        send_byte(8'h4E, ack);
        send_byte(8'h5D, ack);
        send_byte(8'h59, ack);
        pat = 8'h5C;
        for (int i = 7; i >= 0; i--) send_bit(pat[i]);
        sda_m = 1'b1; q();
        chk("pull_before_rst", sda_pull_low, 1);
        reset_p = 1'b1;
        @(negedge clk);
        chk("rst_mid_pull", sda_pull_low, 0);
        chk("rst_mid_outs", {byte_out, backlight, lcd_byte, lcd_rs, busy}, 0);
        scl_m = 1'b1;
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        repeat (4) @(negedge clk);

        lv0 = lv_cnt;
        start_cond();
        send_byte(8'h4E, ack);
        chk("post_rst_ack", ack, 1);
        send_list(8'h2D, 8'h29, 8'h1C, 8'h18);
        repeat (2) @(negedge clk);
        chk("post_rst_lcd_cnt", lv_cnt - lv0, 1);
        chk("post_rst_lcd_byte", lcd_byte, 8'h21);
        stop_cond();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
